// File: rtl/ps2_letter_decoder.sv
// PS/2 device-to-host receiver: deframes set-2 scan codes, tracks E0/F0 prefixes and
// typematic hold, and reports letters A..Z as 1..26, Enter, and framing errors.
module ps2_letter_decoder #(
  parameter int unsigned FILTER_LEN = 8,
  parameter logic [15:0] TIMEOUT    = 16'd50000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [4:0] char,
  output logic       char_valid,
  output logic       enter,
  output logic       frame_err
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam logic [FW-1:0] F_LAST = FW'(FILTER_LEN - 1);
  // Counter holds 0 in the cycle after a fall, so the hit is taken two counts early
  // to make the registered frame_err land exactly TIMEOUT cycles after that fall.
  localparam logic [15:0] TO_HIT = TIMEOUT - 16'd2;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t state, state_n;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          filt, filt_d;
  logic [FW-1:0] fcnt;
  logic          fall;

  logic [2:0]    bitcnt;
  logic [7:0]    shreg;
  logic          par_ok;
  logic [15:0]   tcnt;
  logic          timeout;
  logic          frm_ok, frm_bad;
  logic          byte_rdy;

  logic          ext, brk;
  logic [7:0]    held;
  logic [4:0]    letter;

  always_ff @(posedge clk) begin
    if (resetn) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_dat;
      dat_s2 <= dat_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      filt   <= 1'b1;
      filt_d <= 1'b1;
      fcnt   <= '0;
    end else begin
      filt_d <= filt;
      if (clk_s2 != filt) begin
        if (fcnt == F_LAST) begin
          filt <= clk_s2;
          fcnt <= '0;
        end else begin
          fcnt <= fcnt + FW'(1);
        end
      end else begin
        fcnt <= '0;
      end
    end
  end

  assign fall    = filt_d & ~filt;
  assign timeout = (state != IDLE) && !fall && (tcnt == TO_HIT);

  always_ff @(posedge clk) begin
    if (resetn) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (fall && !dat_s2) state_n = DATA;
      DATA:    if (timeout) state_n = IDLE;
               else if (fall && bitcnt == 3'd7) state_n = PARITY;
      PARITY:  if (timeout) state_n = IDLE;
               else if (fall) state_n = STOP;
      STOP:    if (timeout || fall) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    frm_ok  = 1'b0;
    frm_bad = timeout;
    if (state == STOP && fall) begin
      if (dat_s2 && par_ok) frm_ok  = 1'b1;
      else                  frm_bad = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      bitcnt <= '0;
      shreg  <= '0;
      par_ok <= 1'b0;
      tcnt   <= '0;
    end else begin
      if (state == IDLE || fall) tcnt <= '0;
      else                       tcnt <= tcnt + 16'd1;
      if (fall) begin
        case (state)
          IDLE:   bitcnt <= '0;
          DATA: begin
            shreg  <= {dat_s2, shreg[7:1]};
            bitcnt <= bitcnt + 3'd1;
          end
          PARITY: par_ok <= ^{shreg, dat_s2};
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      byte_rdy  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      byte_rdy  <= frm_ok;
      frame_err <= frm_bad;
    end
  end

  always_comb begin
    letter = '0;
    case (shreg)
      8'h1C: letter = 5'd1;
      8'h32: letter = 5'd2;
      8'h21: letter = 5'd3;
      8'h23: letter = 5'd4;
      8'h24: letter = 5'd5;
      8'h2B: letter = 5'd6;
      8'h34: letter = 5'd7;
      8'h33: letter = 5'd8;
      8'h43: letter = 5'd9;
      8'h3B: letter = 5'd10;
      8'h42: letter = 5'd11;
      8'h4B: letter = 5'd12;
      8'h3A: letter = 5'd13;
      8'h31: letter = 5'd14;
      8'h44: letter = 5'd15;
      8'h4D: letter = 5'd16;
      8'h15: letter = 5'd17;
      8'h2D: letter = 5'd18;
      8'h1B: letter = 5'd19;
      8'h2C: letter = 5'd20;
      8'h3C: letter = 5'd21;
      8'h2A: letter = 5'd22;
      8'h1D: letter = 5'd23;
      8'h22: letter = 5'd24;
      8'h35: letter = 5'd25;
      8'h1A: letter = 5'd26;
      default: letter = '0;
    endcase
  end

  // Held code suppresses typematic repeats until its break code arrives.
  always_ff @(posedge clk) begin
    if (resetn) begin
      char       <= '0;
      char_valid <= 1'b0;
      enter      <= 1'b0;
      ext        <= 1'b0;
      brk        <= 1'b0;
      held       <= '0;
    end else begin
      char_valid <= 1'b0;
      enter      <= 1'b0;
      if (byte_rdy) begin
        if (shreg == 8'hE0) begin
          ext <= 1'b1;
        end else if (shreg == 8'hF0) begin
          brk <= 1'b1;
        end else if (brk) begin
          brk <= 1'b0;
          ext <= 1'b0;
          if (shreg == held) held <= '0;
        end else if (ext) begin
          ext <= 1'b0;
        end else if (shreg != held) begin
          held <= shreg;
          if (letter != 5'd0) begin
            char       <= letter;
            char_valid <= 1'b1;
          end else if (shreg == 8'h5A) begin
            enter <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_letter_decoder.sv
// Drives PS/2 frames into ps2_letter_decoder and compares every output pulse (kind,
// letter and cycle) against a scan-code rule model kept in the bench.
module tb_ps2_letter_decoder;

  localparam int unsigned H  = 25;
  localparam logic [15:0] TO = 16'd400;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [4:0] char;
  logic       char_valid, enter, frame_err;

  ps2_letter_decoder #(.FILTER_LEN(8), .TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .char(char), .char_valid(char_valid), .enter(enter), .frame_err(frame_err)
  );

  always #10 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned kind;
    int unsigned ch;
    int unsigned at;
  } ev_t;

  ev_t expq[$];
  ev_t obsq[$];
  int  checks = 0;
  int  errors = 0;

  logic [7:0] lmap [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                            8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                            8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                            8'h35, 8'h1A};

  bit          m_ext, m_brk;
  logic [7:0]  m_held;
  int unsigned m_char;
  int unsigned last_fall;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic ev_t mk_ev(input int unsigned kind, input int unsigned ch,
                                input int unsigned at);
    ev_t e;
    e.kind = kind;
    e.ch   = ch;
    e.at   = at;
    return e;
  endfunction

  // kind 1 = letter, 2 = enter, 3 = frame error
  always @(negedge clk) begin
    if (char_valid) obsq.push_back(mk_ev(1, 32'(char), cyc));
    if (enter)      obsq.push_back(mk_ev(2, 0, cyc));
    if (frame_err)  obsq.push_back(mk_ev(3, 0, cyc));
    if (char_valid || enter || frame_err)
      check("single_pulse", 32'(char_valid) + 32'(enter) + 32'(frame_err), 1);
  end

  function automatic int unsigned letter_of(input logic [7:0] b);
    for (int i = 0; i < 26; i++)
      if (lmap[i] == b) return i + 1;
    return 0;
  endfunction

  task automatic model_reset();
    m_ext  = 0;
    m_brk  = 0;
    m_held = 8'h00;
    m_char = 0;
  endtask

  task automatic model_byte(input logic [7:0] b, input int unsigned at);
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else if (m_brk) begin
      m_brk = 0;
      m_ext = 0;
      if (b == m_held) m_held = 8'h00;
    end else if (m_ext) m_ext = 0;
    else if (b != m_held) begin
      m_held = b;
      if (letter_of(b) != 0) begin
        m_char = letter_of(b);
        expq.push_back(mk_ev(1, m_char, at));
      end else if (b == 8'h5A) begin
        expq.push_back(mk_ev(2, 0, at));
      end
    end
  endtask

  task automatic wait_cyc(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic v);
    ps2_dat = v;
    wait_cyc(H);
    ps2_clk = 1'b0;
    last_fall = cyc;
    wait_cyc(H);
    ps2_clk = 1'b1;
  endtask

  // Letters/Enter appear 12 clk after the pin fall of the stop bit (2 sync + 8 filter
  // + 2 pipeline), framing errors one cycle earlier.
  task automatic send_frame(input logic [7:0] b, input bit flip_par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ flip_par);
    send_bit(stop);
    ps2_dat = 1'b1;
    if (flip_par || !stop) expq.push_back(mk_ev(3, 0, last_fall + 11));
    else                   model_byte(b, last_fall + 12);
    wait_cyc(H);
  endtask

  task automatic drain(input string tag);
    int unsigned n;
    wait_cyc(20);
    check({tag, "_count"}, obsq.size(), expq.size());
    n = (obsq.size() < expq.size()) ? obsq.size() : expq.size();
    for (int unsigned i = 0; i < n; i++) begin
      check({tag, "_kind"},  obsq[i].kind, expq[i].kind);
      check({tag, "_char"},  obsq[i].ch,   expq[i].ch);
      check({tag, "_cycle"}, obsq[i].at,   expq[i].at);
    end
    obsq.delete();
    expq.delete();
    check({tag, "_char_level"}, 32'(char), m_char);
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] prev;
    model_reset();
    resetn = 1'b1;
    wait_cyc(3);
    check("reset_char", 32'(char), 0);
    check("reset_char_valid", 32'(char_valid), 0);
    check("reset_enter", 32'(enter), 0);
    check("reset_frame_err", 32'(frame_err), 0);
    resetn = 1'b0;
    wait_cyc(5);

    // bad parity then bad stop: char stays 0
    send_frame(8'h24, 1, 1'b1);
    send_frame(8'h24, 0, 1'b0);
    drain("errs");

    send_frame(8'h1C, 0, 1'b1);
    drain("letter_a");

    b = 8'h1A;
    send_frame(b, 0, 1'b1);
    send_frame(b, 0, 1'b1);
    send_frame(b, 0, 1'b1);
    send_frame(8'hF0, 0, 1'b1);
    send_frame(b, 0, 1'b1);
    send_frame(b, 0, 1'b1);
    drain("typematic");

    send_frame(8'hE0, 0, 1'b1);
    send_frame(8'h75, 0, 1'b1);
    send_frame(8'hE0, 0, 1'b1);
    send_frame(8'hF0, 0, 1'b1);
    send_frame(8'h75, 0, 1'b1);
    send_frame(8'h5A, 0, 1'b1);
    drain("ext_enter");

    // abandoned frame: start + 4 data bits, clock held high
    b = 8'h15;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(b[i]);
    ps2_dat = 1'b1;
    expq.push_back(mk_ev(3, 0, last_fall + 10 + 32'(TO)));
    wait_cyc(32'(TO) + 50);
    drain("timeout");
    send_frame(8'h15, 0, 1'b1);
    drain("after_timeout");

    // reset in the middle of a frame
    b = 8'h2D;
    send_bit(1'b0);
    for (int i = 0; i < 6; i++) send_bit(b[i]);
    resetn = 1'b1;
    wait_cyc(1);
    check("midrst_char", 32'(char), 0);
    check("midrst_char_valid", 32'(char_valid), 0);
    check("midrst_frame_err", 32'(frame_err), 0);
    resetn = 1'b0;
    model_reset();
    ps2_dat = 1'b1;
    wait_cyc(H);
    drain("midrst");
    send_frame(8'h2D, 0, 1'b1);
    drain("after_rst");

    prev = 8'h1C;
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: b = lmap[$urandom_range(0, 25)];
        5:       b = 8'hE0;
        6:       b = 8'hF0;
        7:       b = 8'h5A;
        8:       b = prev;
        default: b = 8'($urandom_range(1, 255));
      endcase
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 1) == 0) send_frame(b, 1, 1'b1);
        else                           send_frame(b, 0, 1'b0);
      end else begin
        send_frame(b, 0, 1'b1);
      end
      prev = b;
      if (k % 8 == 7) drain("random");
    end
    drain("random_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_letter_decoder.md
Name: ps2_letter_decoder

Overview:
- Keyboard-side receiver that supplies the game datapath's 5-bit `char` and `guess` letter inputs.
- Deframes the PS/2 device-to-host serial stream and tracks set-2 make/break and E0 prefixes.
- Maps letter keys A..Z to codes 1..26 and pulses a strobe per new key press.
- Also reports Enter (word-entry done) and framing errors to the control FSM.

Parameters:
- FILTER_LEN, 8: consecutive equal synchronized samples required before the filtered ps2_clk level changes.
- TIMEOUT, 16'd50000: clk cycles without a filtered ps2_clk fall, mid-frame, before the frame is aborted.

Ports:
- clk  input  1  system clock
- resetn  input  1  reset; synchronous, active-high despite the name
- ps2_clk  input  1  raw PS/2 clock pin, asynchronous
- ps2_dat  input  1  raw PS/2 data pin, asynchronous
- char  output  5  last accepted letter (1=A..26=Z); 0 = none since reset
- char_valid  output  1  one-cycle pulse when char is updated
- enter  output  1  one-cycle pulse on Enter make (0x5A)
- frame_err  output  1  one-cycle pulse on parity, stop or timeout error

Behaviour:
- Interface: one clock; reset is synchronous and active-high. While resetn=1 on a clk edge, all state clears: sync/filter regs (filtered clk=1), FSM=IDLE, bit count, shift reg, timeout counter, break/ext/held flags. Outputs reset to char=0, char_valid=0, enter=0, frame_err=0. Reset mid-frame discards the partial frame with no pulses.
- Input conditioning:
  - ps2_clk and ps2_dat each pass through a 2-flop synchronizer.
  - Filtered clk toggles only after FILTER_LEN consecutive synchronized samples differ from its current value.
  - A fall event is a 1->0 transition of filtered clk, one cycle wide. Data is sampled from synchronized ps2_dat on that cycle.
- Frame FSM (advances only on fall events):
  - IDLE: sampled 0 -> DATA with bit count 0. Sampled 1 -> stay IDLE, no error.
  - DATA: shift in LSB first. After 8 bits -> PARITY.
  - PARITY: check odd parity over data+parity. Store pass/fail -> STOP.
  - STOP: sampled 1 and parity ok -> byte_rdy. Otherwise frame_err pulse, byte discarded. Both cases -> IDLE.
  - Timeout: in DATA/PARITY/STOP, the counter increments each cycle and clears on every fall event. Reaching TIMEOUT -> frame_err pulse, FSM=IDLE, byte discarded. The counter is held at 0 in IDLE.
- Byte layer (acts on byte_rdy, the cycle after the stop fall event):
  - 0xE0: set ext. 0xF0: set brk. Neither produces output.
  - Other byte with brk=1: release. Clear brk and ext. If byte equals held code, clear held.
  - Other byte with ext=1 (brk=0): ignore, clear ext.
  - Plain make code equal to held code (typematic repeat): suppressed, no pulse.
  - Plain make code: held<=byte. Letter -> char<=code, char_valid pulse. 0x5A -> enter pulse, char unchanged. Any other code -> nothing.
  - Letter map: A 1C, B 32, C 21, D 23, E 24, F 2B, G 34, H 33, I 43, J 3B, K 42, L 4B, M 3A, N 31, O 44, P 4D, Q 15, R 2D, S 1B, T 2C, U 3C, V 2A, W 1D, X 22, Y 35, Z 1A.
- Latency:
  - char, char_valid and enter are registered and assert exactly 2 clk cycles after the stop-bit fall event.
  - Pin to fall event is 2 sync cycles + FILTER_LEN.
  - char holds its value until the next accepted letter.
- frame_err is asserted 1 cycle after the stop fall event or the timeout hit.
- Pulses never coexist: at most one of char_valid, enter and frame_err fires per byte.

Test Plan:
1. Frame 0x1C (start 0, data LSB first, parity 0, stop 1) at 10 kHz PS/2 clk, 50 MHz clk -> char=1, single char_valid pulse 2 cycles after stop fall; enter=0.
2. Bytes 1A, 1A, 1A, F0, 1A, 1A -> exactly two char_valid pulses, char=26 both times. The middle repeats are suppressed and the release re-arms the key.
3. Frame 0x24 with parity bit flipped, then a frame with stop=0 -> two frame_err pulses, char unchanged (0 after reset), no char_valid.
4. Bytes E0 75 E0 F0 75 then 5A -> no char_valid; one enter pulse after 5A; char unchanged.
5. Send start + 4 data bits, then hold ps2_clk high -> frame_err pulse exactly TIMEOUT cycles after the 5th fall event. A following good frame 0x15 yields char=17.
6. Assert resetn for 1 cycle after the 6th data bit of frame 0x2D. Outputs go 0 and there is no pulse for that frame. The next full frame 0x2D yields char=18.
